// File: rtl/encoder_pkg.sv
// ----------------------------------------------------------------------------
// encoder_pkg
// Shared definitions for the 8:3 request encoder.
//   N_LINES        : number of request lines
//   CODE_W         : width of the encoded index
//   state_t        : presenter FSM states (IDLE, PRESENT)
//   first_set_from : index of the first set bit found when scanning upward
//                    from 'start' and wrapping from N_LINES-1 back to 0.
//                    Fixed priority uses start=0; round-robin uses
//                    start = last accepted + 1.
// ----------------------------------------------------------------------------
package encoder_pkg;

    localparam int N_LINES = 8;
    localparam int CODE_W  = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Callers only use the result when vec is non-zero.
    function automatic logic [CODE_W-1:0] first_set_from(
        input logic [N_LINES-1:0] vec,
        input logic [CODE_W-1:0]  start
    );
        logic [CODE_W-1:0] idx;
        logic [CODE_W-1:0] result;
        logic              found;
        result = start;
        found  = 1'b0;
        for (int k = 0; k < N_LINES; k++) begin
            // CODE_W-bit addition wraps 7 -> 0 on its own
            idx = start + CODE_W'(k);
            if (!found && vec[idx]) begin
                result = idx;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fall_detect.sv
// ----------------------------------------------------------------------------
// sync_fall_detect
// Synchronizes one asynchronous active-low line and flags its falling edges.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   async_n : asynchronous active-low input line
//   fall    : high for one cycle when the synchronized line goes 1 -> 0
// All flops reset to 1 (the idle level) so reset release never looks like
// a falling edge.
// ----------------------------------------------------------------------------
module sync_fall_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_n,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '1;
            prev_reg <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_n};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    // Combinational so the pending bit can set on the very next edge.
    assign fall = prev_reg & ~sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/req_encoder_83.sv
// ----------------------------------------------------------------------------
// req_encoder_83
// Sequential 8:3 request encoder with valid/ready handshake. Falling edges
// on eight active-low request lines are captured into a pending set, and
// pending lines are presented one at a time as a 3-bit code.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   en      : enables new selections (capture and handshake always run)
//   req_n   : active-low asynchronous request lines, line i -> code i
//   code    : presented index
//   valid   : code is valid; held until accepted
//   ready   : consumer accepts when valid && ready at a rising edge
//   pending : pending-event set, bit i = line i
//   lost    : one-cycle pulse when an edge hits a line that is already pending
// Parameters: SYNC_STAGES (>=2) synchronizer depth, RR 0 = fixed priority
// (lowest index), 1 = round-robin starting after the last accepted code.
// ----------------------------------------------------------------------------
module req_encoder_83
    import encoder_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit RR          = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  req_n,
    output logic [2:0]  code,
    output logic        valid,
    input  logic        ready,
    output logic [7:0]  pending,
    output logic        lost
);

    logic [N_LINES-1:0] fall_vec;
    logic [N_LINES-1:0] pending_reg;
    logic [N_LINES-1:0] pending_next;
    logic [N_LINES-1:0] accept_mask;
    logic               lost_reg;
    logic               lost_next;
    logic [CODE_W-1:0]  code_reg;
    logic [CODE_W-1:0]  last_reg;
    logic [CODE_W-1:0]  search_start;
    logic [CODE_W-1:0]  pick;
    logic               valid_reg;
    logic               accept;
    state_t             state_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_LINES; gi++) begin : g_line
            sync_fall_detect #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_sync (
                .clk    (clk),
                .rst_n  (rst_n),
                .async_n(req_n[gi]),
                .fall   (fall_vec[gi])
            );
        end
    endgenerate

    always_comb begin
        accept      = (state_reg == PRESENT) && ready;
        accept_mask = '0;
        accept_mask[code_reg] = accept;
        // A fall on the line being accepted this cycle is a fresh event:
        // the bit stays set and no lost pulse is raised.
        pending_next = (pending_reg & ~accept_mask) | fall_vec;
        lost_next    = |(fall_vec & pending_reg & ~accept_mask);
        // Pointer resets to 7, so round-robin's first search starts at 0.
        search_start = RR ? (last_reg + 3'd1) : '0;
        pick         = first_set_from(pending_reg, search_start);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            code_reg    <= '0;
            valid_reg   <= 1'b0;
            last_reg    <= 3'd7;
            pending_reg <= '0;
            lost_reg    <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            lost_reg    <= lost_next;
            case (state_reg)
                IDLE: begin
                    if (en && (pending_reg != '0)) begin
                        code_reg  <= pick;
                        valid_reg <= 1'b1;
                        state_reg <= PRESENT;
                    end
                end
                PRESENT: begin
                    // en is deliberately ignored: a presented code is only
                    // withdrawn through a handshake.
                    if (ready) begin
                        last_reg  <= code_reg;
                        valid_reg <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign code    = code_reg;
    assign valid   = valid_reg;
    assign pending = pending_reg;
    assign lost    = lost_reg;

endmodule

// File: tb/tb_req_encoder_83.sv
// ----------------------------------------------------------------------------
// tb_req_encoder_83
// Drives a fixed-priority and a round-robin encoder with the same stimulus and
// compares both against an event-level reference model every cycle.
// ----------------------------------------------------------------------------
module tb_req_encoder_83;

    localparam int S = 2;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        ready;
    logic [7:0]  req_n;
    logic [2:0]  code_w    [2];
    logic        valid_w   [2];
    logic [7:0]  pending_w [2];
    logic        lost_w    [2];

    req_encoder_83 #(.SYNC_STAGES(S), .RR(1'b0)) u_fix (
        .clk(clk), .rst_n(rst_n), .en(en), .req_n(req_n),
        .code(code_w[0]), .valid(valid_w[0]), .ready(ready),
        .pending(pending_w[0]), .lost(lost_w[0])
    );

    req_encoder_83 #(.SYNC_STAGES(S), .RR(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n), .en(en), .req_n(req_n),
        .code(code_w[1]), .valid(valid_w[1]), .ready(ready),
        .pending(pending_w[1]), .lost(lost_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_mis = 0;

    // reference model state
    bit [7:0] hist [S+2];      // hist[k] = req_n sampled k edges ago
    bit [7:0] m_pend [2];
    bit       m_val  [2];
    bit [2:0] m_code [2];
    bit [2:0] m_last [2];
    bit       m_lost [2];

    bit [2:0] acc_q [2][$];
    int       lost_cnt [2];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%02h exp=%02h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [2:0] model_pick(input bit [7:0] p, input int start);
        for (int k = 0; k < 8; k++) begin
            int i;
            i = (start + k) % 8;
            if (p[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < S + 2; k++) hist[k] = 8'hFF;
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = '0;
            m_val[d]  = 1'b0;
            m_code[d] = '0;
            m_last[d] = 3'd7;
            m_lost[d] = 1'b0;
        end
    endtask

    // One rising edge worth of behaviour, using the inputs applied at that edge.
    task automatic model_step(input bit [7:0] r, input bit e, input bit rd);
        bit [7:0] falls;
        for (int k = S + 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = r;
        // an event is a high sample followed by a low sample, seen S edges late
        falls = ~hist[S] & hist[S+1];
        for (int d = 0; d < 2; d++) begin
            bit [7:0] acc;
            bit [7:0] old;
            acc = '0;
            old = m_pend[d];
            if (m_val[d] && rd) acc[m_code[d]] = 1'b1;
            m_lost[d] = |(falls & old & ~acc);
            m_pend[d] = (old & ~acc) | falls;
            if (m_val[d] && rd) begin
                m_val[d]  = 1'b0;
                m_last[d] = m_code[d];
            end else if (!m_val[d] && e && old != 0) begin
                m_code[d] = model_pick(old, (d == 1) ? (int'(m_last[d]) + 1) % 8 : 0);
                m_val[d]  = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("code%0d", d),    8'(code_w[d]),  8'(m_code[d]));
            check($sformatf("valid%0d", d),   8'(valid_w[d]), 8'(m_val[d]));
            check($sformatf("pending%0d", d), pending_w[d],   m_pend[d]);
            check($sformatf("lost%0d", d),    8'(lost_w[d]),  8'(m_lost[d]));
        end
    endtask

    // Called 1 time unit after a rising edge; applies inputs, takes one edge.
    task automatic cycle(input bit [7:0] r, input bit e, input bit rd);
        req_n = r;
        en    = e;
        ready = rd;
        for (int d = 0; d < 2; d++) begin
            if (valid_w[d] && rd) begin
                acc_q[d].push_back(code_w[d]);
                $display("dut%0d accept code=%0d t=%0t", d, code_w[d], $time);
            end
        end
        @(posedge clk);
        model_step(r, e, rd);
        #1;
        check_all();
        for (int d = 0; d < 2; d++) lost_cnt[d] += int'(lost_w[d]);
    endtask

    task automatic check_reset_vals(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_code%0d", tag, d),  8'(code_w[d]),  8'h00);
            check($sformatf("%s_valid%0d", tag, d), 8'(valid_w[d]), 8'h00);
            check($sformatf("%s_pend%0d", tag, d),  pending_w[d],   8'h00);
            check($sformatf("%s_lost%0d", tag, d),  8'(lost_w[d]),  8'h00);
        end
    endtask

    task automatic clear_logs();
        for (int d = 0; d < 2; d++) begin
            acc_q[d].delete();
            lost_cnt[d] = 0;
        end
    endtask

    initial begin
        bit [7:0] r;
        bit       e;
        bit       rd;

        rst_n = 1'b0;
        req_n = 8'hFF;
        en    = 1'b1;
        ready = 1'b0;
        model_reset();
        clear_logs();

        // reset values, then release with all lines idle
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst_n = 1'b1;
        repeat (4) cycle(8'hFF, 1'b1, 1'b1);
        check("no_spurious", pending_w[0] | pending_w[1], 8'h00);

        // single request on line 5: pending at edge S, valid at edge S+1
        for (int i = 0; i <= S + 2; i++) begin
            cycle(8'hDF, 1'b1, 1'b1);
            if (i == S) check("l5_pend", pending_w[0], 8'h20);
            if (i == S + 1) begin
                check("l5_valid", 8'(valid_w[0]), 8'h01);
                check("l5_code",  8'(code_w[0]),  8'h05);
            end
            if (i == S + 2) begin
                check("l5_drop",  8'(valid_w[0]), 8'h00);
                check("l5_clear", pending_w[0],   8'h00);
            end
        end
        repeat (4) cycle(8'hFF, 1'b1, 1'b1);

        // line 0 alone so the round-robin pointer ends at 0, then lines 0 and 3
        repeat (6) cycle(8'hFE, 1'b1, 1'b1);
        repeat (4) cycle(8'hFF, 1'b1, 1'b1);
        clear_logs();
        repeat (8) cycle(8'hF6, 1'b1, 1'b1);
        repeat (4) cycle(8'hFF, 1'b1, 1'b1);
        check("fix_n", 8'(acc_q[0].size()), 8'd2);
        check("rr_n",  8'(acc_q[1].size()), 8'd2);
        if (acc_q[0].size() == 2 && acc_q[1].size() == 2) begin
            check("fix_first", 8'(acc_q[0][0]), 8'd0);
            check("fix_second", 8'(acc_q[0][1]), 8'd3);
            check("rr_first",  8'(acc_q[1][0]), 8'd3);
            check("rr_second", 8'(acc_q[1][1]), 8'd0);
        end

        // hold with ready=0 while en toggles; a new fall on line 2 meanwhile
        repeat (4) cycle(8'hFD, 1'b1, 1'b0);
        repeat (3) cycle(8'hFD, 1'b0, 1'b0);
        repeat (2) cycle(8'hFD, 1'b1, 1'b0);
        repeat (4) cycle(8'hF9, 1'b1, 1'b0);
        check("hold_code",  8'(code_w[0]),  8'd1);
        check("hold_valid", 8'(valid_w[0]), 8'd1);
        check("hold_p2",    8'(pending_w[0][2]), 8'd1);
        repeat (6) cycle(8'hF9, 1'b1, 1'b1);
        repeat (4) cycle(8'hFF, 1'b1, 1'b1);

        // duplicate fall on pending line 4 -> one lost pulse, one code
        clear_logs();
        repeat (4) cycle(8'hEF, 1'b1, 1'b0);
        repeat (3) cycle(8'hFF, 1'b1, 1'b0);
        repeat (3) cycle(8'hEF, 1'b1, 1'b0);
        repeat (2) cycle(8'hEF, 1'b1, 1'b1);
        repeat (4) cycle(8'hFF, 1'b1, 1'b1);
        check("dup_lost", 8'(lost_cnt[0]), 8'd1);
        check("dup_codes", 8'(acc_q[0].size()), 8'd1);

        // fall on line 4 at the same edge its code is accepted -> no lost, two codes
        clear_logs();
        repeat (4) cycle(8'hEF, 1'b1, 1'b0);
        repeat (3) cycle(8'hFF, 1'b1, 1'b0);
        repeat (S) cycle(8'hEF, 1'b1, 1'b0);
        cycle(8'hEF, 1'b1, 1'b1);
        check("same_p4", 8'(pending_w[0][4]), 8'd1);
        repeat (4) cycle(8'hEF, 1'b1, 1'b1);
        repeat (4) cycle(8'hFF, 1'b1, 1'b1);
        check("same_lost", 8'(lost_cnt[0]), 8'd0);
        check("same_codes", 8'(acc_q[0].size()), 8'd2);

        // asynchronous reset while presenting with three lines pending
        repeat (4) cycle(8'hE3, 1'b1, 1'b0);
        check("pre_rst_valid", 8'(valid_w[0]), 8'd1);
        check("pre_rst_pend",  pending_w[0],   8'h1C);
        #2;
        rst_n = 1'b0;
        req_n = 8'hFF;
        #1;
        check_reset_vals("arst");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) cycle(8'hFF, 1'b1, 1'b1);
        check("post_rst_valid", 8'(valid_w[0] | valid_w[1]), 8'd0);

        // randomized traffic
        r = 8'hFF;
        for (int n = 0; n < 1500; n++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            e  = ($urandom_range(0, 9) != 0);
            rd = ($urandom_range(0, 2) != 0);
            cycle(r, e, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
